// File: rtl/exc_seq.sv
// exc_seq: exception/interrupt entry-and-return sequencer; define EXC_SEQ_SYNC_EN to add a two-flop synchronizer on hwint_raw
module exc_seq #(
  parameter logic [31:0] HANDLER = 32'h0000_4180,
  parameter logic [4:0]  EPC_SEL = 5'd14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  i_hwint_raw,
  input  logic [5:0]  i_irq_clr,
  input  logic        i_int_req,
  input  logic [31:0] i_epc,
  input  logic        i_instr_done,
  input  logic        i_eret,
  input  logic [31:0] i_pc_next,
  output logic [5:0]  o_hwint,
  output logic        o_stall,
  output logic        o_exl_set,
  output logic        o_exl_clr,
  output logic        o_cp0_wen,
  output logic [4:0]  o_cp0_sel,
  output logic [31:0] o_cp0_pc,
  output logic        o_pc_load,
  output logic [31:0] o_pc_target,
  output logic [2:0]  o_last_id
);
  typedef enum logic [2:0] {S_IDLE, S_EXL, S_SAVE, S_VEC, S_RET} state_t;
  state_t      r_state, w_next;
  logic [5:0]  w_src, r_prev, r_hwint;
  logic [31:0] r_save_pc;
  logic [2:0]  r_last_id, w_low_id;
  logic        w_take, w_unused;
  assign w_unused = ^i_epc[1:0];
`ifdef EXC_SEQ_SYNC_EN
  logic [5:0] r_s1, r_s2;
  // two-flop synchronizer for device lines from other clock domains
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_hwint_raw;
      r_s2 <= r_s1;
    end
  assign w_src = r_s2;
`else
  assign w_src = i_hwint_raw;
`endif
  // rising edges set pending bits; a same-cycle set overrides the clear
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_prev  <= '0;
      r_hwint <= '0;
    end else begin
      r_prev  <= w_src;
      r_hwint <= (r_hwint & ~i_irq_clr) | (w_src & ~r_prev);
    end
  // lowest pending index, 7 when nothing is pending
  always_comb begin
    w_low_id = 3'd7;
    for (int k = 5; k >= 0; k--)
      if (r_hwint[k]) w_low_id = 3'(k);
  end
  assign w_take = (r_state == S_IDLE) & i_instr_done & ~i_eret & i_int_req;
  // state register plus the return PC and source id captured at entry
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state   <= S_IDLE;
      r_save_pc <= '0;
      r_last_id <= 3'd7;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_save_pc <= i_pc_next;
        r_last_id <= w_low_id;
      end
    end
  // next state and one-cycle strobes decoded from the current state
  always_comb begin
    w_next      = S_IDLE;
    o_exl_set   = 1'b0;
    o_exl_clr   = 1'b0;
    o_cp0_wen   = 1'b0;
    o_cp0_sel   = 5'd0;
    o_cp0_pc    = r_save_pc;
    o_pc_load   = 1'b0;
    o_pc_target = 32'd0;
    case (r_state)
      S_IDLE: w_next = !i_instr_done ? S_IDLE : i_eret ? S_RET : i_int_req ? S_EXL : S_IDLE;
      S_EXL: begin
        w_next    = S_SAVE;
        o_exl_set = 1'b1;
      end
      S_SAVE: begin
        w_next    = S_VEC;
        o_cp0_wen = 1'b1;
        o_cp0_sel = EPC_SEL;
        o_cp0_pc  = {r_save_pc[31:2], 2'b00};
      end
      S_VEC: begin
        o_pc_load   = 1'b1;
        o_pc_target = HANDLER;
      end
      S_RET: begin
        o_pc_load   = 1'b1;
        o_pc_target = {i_epc[31:2], 2'b00};
        o_exl_clr   = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end
  assign o_stall   = r_state != S_IDLE;
  assign o_hwint   = r_hwint;
  assign o_last_id = r_last_id;
endmodule

// File: tb/tb_exc_seq.sv
// tb_exc_seq: directed table, corner sequences and randomized run against a schedule-queue model
module tb_exc_seq;
`ifdef EXC_SEQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  logic        clk = 1'b0, rst = 1'b0;
  logic [5:0]  hwint_raw = '0, irq_clr = '0;
  logic        int_req = 1'b0, instr_done = 1'b0, eret = 1'b0;
  logic [31:0] epc = '0, pc_next = '0;
  logic [5:0]  hwint;
  logic        stall, exl_set, exl_clr, cp0_wen, pc_load;
  logic [4:0]  cp0_sel;
  logic [31:0] cp0_pc, pc_target;
  logic [2:0]  last_id;
  int checks = 0, errors = 0;
  int cur;
  int q[$];
  logic [31:0] m_sp;
  logic [2:0]  m_lid;
  logic [5:0]  m_pend;
  logic [5:0]  rh[4];

  exc_seq dut (
    .clk(clk), .rst(rst), .i_hwint_raw(hwint_raw), .i_irq_clr(irq_clr), .i_int_req(int_req),
    .i_epc(epc), .i_instr_done(instr_done), .i_eret(eret), .i_pc_next(pc_next),
    .o_hwint(hwint), .o_stall(stall), .o_exl_set(exl_set), .o_exl_clr(exl_clr),
    .o_cp0_wen(cp0_wen), .o_cp0_sel(cp0_sel), .o_cp0_pc(cp0_pc), .o_pc_load(pc_load),
    .o_pc_target(pc_target), .o_last_id(last_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic done, ert, irq;
    logic [31:0] pcn, epcv;
    logic stall, xs, xc, wen;
    logic [4:0] sel;
    logic [31:0] cpc;
    logic ld;
    logic [31:0] tgt;
  } vec_t;
  vec_t tv[14];

  function automatic vec_t mk(input logic d, input logic e, input logic r, input logic [31:0] pn,
                              input logic [31:0] ev, input logic s, input logic xs, input logic xc,
                              input logic w, input logic [4:0] sl, input logic [31:0] cp,
                              input logic l, input logic [31:0] t);
    vec_t v;
    v.done = d; v.ert = e; v.irq = r; v.pcn = pn; v.epcv = ev;
    v.stall = s; v.xs = xs; v.xc = xc; v.wen = w; v.sel = sl; v.cpc = cp; v.ld = l; v.tgt = t;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    instr_done = 1'b0; eret = 1'b0; int_req = 1'b0; irq_clr = '0;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, " stall"}, {31'd0, stall}, 32'd0);
    chk({nm, " strobes"}, {28'd0, exl_set, exl_clr, cp0_wen, pc_load}, 32'd0);
  endtask

  task automatic chk_out(input int c);
    chk("rnd stall", {31'd0, stall}, {31'd0, c != 0});
    chk("rnd exl_set", {31'd0, exl_set}, {31'd0, c == 1});
    chk("rnd exl_clr", {31'd0, exl_clr}, {31'd0, c == 4});
    chk("rnd cp0_wen", {31'd0, cp0_wen}, {31'd0, c == 2});
    chk("rnd cp0_sel", {27'd0, cp0_sel}, c == 2 ? 32'd14 : 32'd0);
    chk("rnd cp0_pc", cp0_pc, c == 2 ? (m_sp & ~32'h3) : m_sp);
    chk("rnd pc_load", {31'd0, pc_load}, {31'd0, c == 3 || c == 4});
    chk("rnd pc_target", pc_target, c == 3 ? 32'h0000_4180 : c == 4 ? (epc & ~32'h3) : 32'd0);
    chk("rnd last_id", {29'd0, last_id}, {29'd0, m_lid});
    chk("rnd hwint", {26'd0, hwint}, {26'd0, m_pend});
  endtask

  function automatic logic [2:0] lowest(input logic [5:0] p);
    for (int k = 0; k < 6; k++)
      if (p[k]) return 3'(k);
    return 3'd7;
  endfunction

  task automatic model_edge();
    logic [2:0] lo;
    logic [5:0] src, prv;
    lo = lowest(m_pend);
    if (cur == 0) begin
      if (instr_done && eret) cur = 4;
      else if (instr_done && int_req) begin
        cur = 1; q.push_back(2); q.push_back(3); m_sp = pc_next; m_lid = lo;
      end
    end else cur = (q.size() != 0) ? q.pop_front() : 0;
    rh[3] = rh[2]; rh[2] = rh[1]; rh[1] = rh[0]; rh[0] = hwint_raw;
    src = rh[LAT - 1]; prv = rh[LAT];
    m_pend = (m_pend & ~irq_clr) | (src & ~prv);
  endtask

  task automatic entry(input logic [31:0] pn);
    instr_done = 1'b1; int_req = 1'b1; pc_next = pn;
    cyc();
    idle_in();
  endtask

  initial begin
    // reset state
    cyc(); cyc();
    chk("rst stall", {31'd0, stall}, 32'd0);
    chk("rst strobes", {28'd0, exl_set, exl_clr, cp0_wen, pc_load}, 32'd0);
    chk("rst cp0_sel", {27'd0, cp0_sel}, 32'd0);
    chk("rst cp0_pc", cp0_pc, 32'd0);
    chk("rst pc_target", pc_target, 32'd0);
    chk("rst hwint", {26'd0, hwint}, 32'd0);
    chk("rst last_id", {29'd0, last_id}, 32'd7);
    rst = 1'b1;
    cyc();
    // entry, ERET with int_req, back-to-back, instr_done ignored while busy
    tv[0]  = mk(1,0,1,32'h3008,0,     1,1,0,0,0, 32'h3008,0,0);
    tv[1]  = mk(1,0,1,32'h3008,0,     1,0,0,1,14,32'h3008,0,0);
    tv[2]  = mk(1,0,0,32'h1234,0,     1,0,0,0,0, 32'h3008,1,32'h4180);
    tv[3]  = mk(0,0,0,0,0,            0,0,0,0,0, 32'h3008,0,0);
    tv[4]  = mk(1,1,1,0,32'h300B,     1,0,1,0,0, 32'h3008,1,32'h3008);
    tv[5]  = mk(0,0,0,0,0,            0,0,0,0,0, 32'h3008,0,0);
    tv[6]  = mk(1,0,1,32'h5003,0,     1,1,0,0,0, 32'h5003,0,0);
    tv[7]  = mk(0,0,0,0,0,            1,0,0,1,14,32'h5000,0,0);
    tv[8]  = mk(1,0,1,32'h7000,0,     1,0,0,0,0, 32'h5003,1,32'h4180);
    tv[9]  = mk(0,0,0,0,0,            0,0,0,0,0, 32'h5003,0,0);
    tv[10] = mk(1,0,1,32'h6000,0,     1,1,0,0,0, 32'h6000,0,0);
    tv[11] = mk(0,0,0,0,0,            1,0,0,1,14,32'h6000,0,0);
    tv[12] = mk(1,0,1,32'h9999,0,     1,0,0,0,0, 32'h6000,1,32'h4180);
    tv[13] = mk(0,0,0,0,0,            0,0,0,0,0, 32'h6000,0,0);
    for (int i = 0; i < 14; i++) begin
      instr_done = tv[i].done; eret = tv[i].ert; int_req = tv[i].irq;
      pc_next = tv[i].pcn; epc = tv[i].epcv;
      cyc();
      chk($sformatf("row%0d stall", i), {31'd0, stall}, {31'd0, tv[i].stall});
      chk($sformatf("row%0d exl_set", i), {31'd0, exl_set}, {31'd0, tv[i].xs});
      chk($sformatf("row%0d exl_clr", i), {31'd0, exl_clr}, {31'd0, tv[i].xc});
      chk($sformatf("row%0d cp0_wen", i), {31'd0, cp0_wen}, {31'd0, tv[i].wen});
      chk($sformatf("row%0d cp0_sel", i), {27'd0, cp0_sel}, {27'd0, tv[i].sel});
      chk($sformatf("row%0d cp0_pc", i), cp0_pc, tv[i].cpc);
      chk($sformatf("row%0d pc_load", i), {31'd0, pc_load}, {31'd0, tv[i].ld});
      chk($sformatf("row%0d pc_target", i), pc_target, tv[i].tgt);
      chk($sformatf("row%0d last_id", i), {29'd0, last_id}, 32'd7);
    end
    idle_in();
    // int_req without a boundary never starts a sequence
    int_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk_quiet($sformatf("noboundary%0d", i));
    end
    idle_in();
    // pending: pulse, clear, held level, set beats clear
    hwint_raw = 6'b000100;
    for (int k = 1; k <= LAT; k++) begin
      cyc();
      if (k == 1) hwint_raw = 6'b000000;
      chk($sformatf("pend lat%0d", k), {26'd0, hwint}, k == LAT ? 32'h4 : 32'h0);
    end
    irq_clr = 6'b000100;
    cyc();
    irq_clr = '0;
    chk("pend clear", {26'd0, hwint}, 32'd0);
    hwint_raw = 6'b000100;
    repeat (LAT + 1) cyc();
    irq_clr = 6'b000100;
    cyc();
    irq_clr = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("pend held%0d", i), {26'd0, hwint}, 32'd0);
    end
    hwint_raw = '0;
    repeat (LAT + 1) cyc();
    hwint_raw = 6'b000100;
    for (int k = 1; k <= LAT; k++) begin
      if (k == LAT) irq_clr = 6'b000100;
      cyc();
      irq_clr = '0;
    end
    chk("pend set_wins", {26'd0, hwint}, 32'h4);
    hwint_raw = '0; irq_clr = 6'b000100;
    cyc();
    irq_clr = '0;
    // last_id capture
    hwint_raw = 6'b101000;
    repeat (LAT) cyc();
    hwint_raw = '0;
    chk("lid hwint", {26'd0, hwint}, 32'h28);
    entry(32'h100);
    chk("lid exl_set", {31'd0, exl_set}, 32'd1);
    chk("lid three", {29'd0, last_id}, 32'd3);
    repeat (3) cyc();
    irq_clr = 6'b101000;
    cyc();
    irq_clr = '0;
    chk("lid cleared", {26'd0, hwint}, 32'd0);
    entry(32'h200);
    chk("lid none", {29'd0, last_id}, 32'd7);
    repeat (3) cyc();
    // reset in SAVE aborts the sequence
    hwint_raw = 6'b000001;
    repeat (LAT) cyc();
    hwint_raw = '0;
    entry(32'h300);
    chk("mid lid", {29'd0, last_id}, 32'd0);
    cyc();
    chk("mid in save", {31'd0, cp0_wen}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid stall", {31'd0, stall}, 32'd0);
    chk("mid strobes", {28'd0, exl_set, exl_clr, cp0_wen, pc_load}, 32'd0);
    chk("mid cp0_sel", {27'd0, cp0_sel}, 32'd0);
    chk("mid cp0_pc", cp0_pc, 32'd0);
    chk("mid last_id", {29'd0, last_id}, 32'd7);
    chk("mid hwint", {26'd0, hwint}, 32'd0);
    cyc();
    chk_quiet("mid held");
    rst = 1'b1;
    cyc();
    chk_quiet("mid released");
    entry(32'h400);
    chk("mid reentry exl_set", {31'd0, exl_set}, 32'd1);
    chk("mid reentry cp0_pc", cp0_pc, 32'h400);
    repeat (3) cyc();
    // randomized run against the schedule model
    idle_in(); hwint_raw = '0;
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    cur = 0; q.delete(); m_sp = '0; m_lid = 3'd7; m_pend = '0;
    for (int i = 0; i < 4; i++) rh[i] = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(5) == 0) hwint_raw = hwint_raw ^ 6'(1 << $urandom_range(5));
      irq_clr    = ($urandom_range(4) == 0) ? 6'($urandom) : 6'd0;
      instr_done = $urandom_range(2) == 0;
      eret       = instr_done && ($urandom_range(3) == 0);
      int_req    = 1'($urandom_range(1));
      pc_next    = $urandom;
      epc        = $urandom;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk_out(cur);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exc_seq.md
# exc_seq

Exception/interrupt entry-and-return sequencer for the multi-cycle MIPS-lite core. It latches device interrupt lines into pending bits for the CP0 `HWint` input. It watches CP0's interrupt request at instruction boundaries and runs a fixed multi-cycle sequence: set EXL, write EPC, redirect the PC to the handler. On `eret` it reloads the PC from EPC and clears EXL. It sits between the control unit, the PC register and CP0, and stalls the core while a sequence is in flight.

## Interface
- `HANDLER`, default 32'h0000_4180: exception vector loaded into the PC on entry.
- `EPC_SEL`, default 5'd14: CP0 register index of EPC.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `hwint_raw` in 6: raw device interrupt lines, level.
- `irq_clr` in 6: one-cycle pulses, each clears the matching pending bit.
- `int_req` in 1: CP0 IntReq.
- `epc` in 32: CP0 epcout.
- `instr_done` in 1: one-cycle pulse when the current instruction retires; marks the instruction boundary.
- `eret` in 1: the retiring instruction is ERET; valid only with `instr_done`.
- `pc_next` in 32: address of the next instruction; valid with `instr_done`.
- `hwint` out 6: pending bits to CP0 HWint.
- `stall` out 1: core must hold its state.
- `exl_set` out 1: CP0 EXLset pulse.
- `exl_clr` out 1: CP0 EXLclr pulse.
- `cp0_wen` out 1: CP0 write enable.
- `cp0_sel` out 5: CP0 register select.
- `cp0_pc` out 32: PC value presented to CP0 for the EPC write.
- `pc_load` out 1: PC register load strobe.
- `pc_target` out 32: value to load into the PC.
- `last_id` out 3: index of the lowest pending source at entry; 3'd7 = none.

## Operation
- Pending logic:
  - A rising edge of a (synchronized) `hwint_raw[i]` sets `hwint[i]`.
  - `irq_clr[i]` clears `hwint[i]`.
  - If a set and a clear of the same bit fall in the same cycle, the set wins.
  - A level held high does not re-set the bit after a clear.
- FSM states: IDLE, EXL, SAVE, VEC, RET. All state changes occur on the rising edge of `clk`.
- IDLE:
  - `instr_done & eret` → RET. ERET has priority even if `int_req` is high.
  - `instr_done & int_req & !eret` → EXL. On this edge, capture `pc_next` into `save_pc` and capture `last_id` = the lowest set index of `hwint`, or 7 if none is set.
  - Otherwise stay in IDLE.
- EXL: `exl_set`=1 for one cycle → SAVE.
- SAVE: `cp0_wen`=1, `cp0_sel`=`EPC_SEL`, `cp0_pc`=`save_pc` (bits [1:0] forced to 00) → VEC.
- VEC: `pc_load`=1, `pc_target`=`HANDLER` → IDLE.
- RET: `pc_load`=1, `pc_target`={`epc`[31:2],2'b00}, `exl_clr`=1 → IDLE.
- `stall` = (state != IDLE). Strobes (`exl_set`, `exl_clr`, `cp0_wen`, `pc_load`) are decoded from state and are high for exactly one cycle per visit.
- Outside SAVE: `cp0_wen`=0, `cp0_sel`=0, `cp0_pc`=`save_pc`.
- Outside VEC/RET: `pc_target`=0.
- `instr_done` is ignored outside IDLE.
- `int_req` without `instr_done` never starts a sequence; interrupts are taken only at boundaries.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, `hwint`=0, `save_pc`=0, `last_id`=7, all outputs 0 except `last_id`. Synchronizer flops are cleared.
- Reset asserted mid-sequence aborts the sequence immediately; no further strobes are issued.
- Entry latency: `instr_done` edge at cycle N → `exl_set` in N+1, `cp0_wen` in N+2, `pc_load` in N+3 → IDLE at N+4. `stall` is high for cycles N+1 through N+3.
- Return latency: `pc_load` and `exl_clr` in N+1; `stall` high for 1 cycle.
- `hwint_raw` edge → `hwint` set: 1 cycle without the synchronizer, 3 cycles with it.
- Back-to-back: an `instr_done` arriving in the cycle the FSM returns to IDLE is accepted normally.

## Configuration
- `EXC_SEQ_SYNC_EN` defined: each `hwint_raw` bit passes through a two-flop synchronizer before the edge-detect register (3-cycle set latency).
- `EXC_SEQ_SYNC_EN` undefined: `hwint_raw` feeds the edge-detect register directly (1-cycle set latency). Suitable only for synchronous on-chip devices.

## Test plan
- Pending bits: pulse `hwint_raw`=6'b000100 → `hwint`=6'b000100 after the configured latency; `irq_clr`=6'b000100 → 0. Holding `hwint_raw` high after the clear leaves the bit at 0.
- Interrupt entry: `int_req`=1 with `instr_done`, `pc_next`=32'h0000_3008 → `exl_set` N+1; `cp0_wen`=1, `cp0_sel`=14, `cp0_pc`=32'h0000_3008 at N+2; `pc_load`=1, `pc_target`=32'h0000_4180 at N+3; `stall` high for exactly 3 cycles.
- ERET: `instr_done`=`eret`=1 with `epc`=32'h0000_300B → at N+1 `pc_load`=1, `pc_target`=32'h0000_3008, `exl_clr`=1; no `exl_set` issued.
- Priority/boundary: `eret` and `int_req` together → RET path only. `int_req`=1 without `instr_done` for 10 cycles → no strobes. `instr_done` during SAVE → ignored.
- `last_id`: `hwint`=6'b101000 at entry → `last_id`=3; entry with `hwint`=0 → `last_id`=7.
- Reset mid-sequence: assert `rst`=0 in SAVE → all outputs 0 immediately, `last_id`=7; after release the FSM is in IDLE and accepts a new entry.
